// File: rtl/neurram_pkg.sv
// Shared definitions for the NeuRRAM core readout path.
package neurram_pkg;

  localparam int WORD_W      = 32;
  localparam int NUM_BITS_W  = 12;
  localparam int WORD_IDX_W  = 5;

  // Readout FSM state encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_PUSH  = 3'd3,
    S_DONE  = 3'd4
  } rd_state_e;

  // Return word with bit position idx replaced by b.
  function automatic logic [WORD_W-1:0] pack_bit(
    input logic [WORD_W-1:0]     word,
    input logic [WORD_IDX_W-1:0] idx,
    input logic                  b
  );
    logic [WORD_W-1:0] r;
    r      = word;
    r[idx] = b;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo32.sv
// Synchronous 32-bit FIFO with registered read port (latency 1).
// Pointers carry one extra wrap bit to distinguish full from empty.
module sync_fifo32
  import neurram_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] din,
  output logic              full,
  input  logic              rd_en,
  output logic [WORD_W-1:0] dout,
  output logic              empty,
  output logic              valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              wr_ok_s;
  logic              rd_ok_s;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wr_ok_s = wr_en & ~full;
  assign rd_ok_s = rd_en & ~empty;
  assign dout    = dout_q;
  assign valid   = valid_q;

  // Next pointer and read-port values.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (wr_ok_s) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_ok_s) begin
      rptr_d  = rptr_q + {{AW{1'b0}}, 1'b1};
      dout_d  = mem_q[rptr_q[AW-1:0]];
      valid_d = 1'b1;
    end else begin
      rptr_d  = rptr_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
    end
  end

  // Pointer and read-port registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Storage array; contents are discarded logically by the pointer reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/core_readout_packer.sv
// Per-core readout stage: strobes the core's serial output register,
// packs bits LSB-first into 32-bit words and queues them in a FIFO that
// the pipe-out arbiter drains through a standard read interface.
module core_readout_packer
  import neurram_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int SHIFT_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_BITS_W-1:0] num_bits,
  output logic                  busy,
  output logic                  done,
  output logic                  so_shift,
  input  logic                  so_data,
  input  logic                  rd_en,
  output logic [WORD_W-1:0]     dout,
  output logic                  empty,
  output logic                  valid
);

  localparam int               DIV_W    = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

  rd_state_e             state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [NUM_BITS_W-1:0] bitcnt_q, bitcnt_d;
  logic [NUM_BITS_W-1:0] nbits_q, nbits_d;
  logic [WORD_W-1:0]     shreg_q, shreg_d;
  logic                  busy_q, done_q, so_shift_q;
  logic                  fifo_wr_s;
  logic                  fifo_full_s;

  assign busy     = busy_q;
  assign done     = done_q;
  assign so_shift = so_shift_q;

  // Readout FSM next-state, divider, bit counter and shift register update.
  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    bitcnt_d  = bitcnt_q;
    nbits_d   = nbits_q;
    shreg_d   = shreg_q;
    fifo_wr_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_bits == {NUM_BITS_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            nbits_d  = num_bits;
            bitcnt_d = '0;
            shreg_d  = '0;
            state_d  = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      S_SHIFT: begin
        // Entry to SHIFT only follows a push or a non-full register, so
        // the shift register always has room for this bit.
        shreg_d  = pack_bit(shreg_q, bitcnt_q[WORD_IDX_W-1:0], so_data);
        bitcnt_d = bitcnt_q + {{(NUM_BITS_W-1){1'b0}}, 1'b1};
        if ((bitcnt_q[WORD_IDX_W-1:0] == 5'd31) || (bitcnt_d == nbits_q)) begin
          state_d = S_PUSH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_PUSH: begin
        // A full FIFO stalls here; a same-cycle read does not unblock it.
        if (!fifo_full_s) begin
          fifo_wr_s = 1'b1;
          shreg_d   = '0;
          if (bitcnt_q == nbits_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_PUSH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bitcnt_q   <= '0;
      nbits_q    <= '0;
      shreg_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      so_shift_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bitcnt_q   <= bitcnt_d;
      nbits_q    <= nbits_d;
      shreg_q    <= shreg_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_q == S_DONE);
      so_shift_q <= (state_d == S_SHIFT);
    end
  end

  sync_fifo32 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (fifo_wr_s),
    .din   (shreg_q),
    .full  (fifo_full_s),
    .rd_en (rd_en),
    .dout  (dout),
    .empty (empty),
    .valid (valid)
  );

endmodule

// File: tb/tb_core_readout_packer.sv
// Scoreboard bench for core_readout_packer: two instances (FIFO depth 16
// and depth 2) share stimulus; a select picks which one is active.
module tb_core_readout_packer;
  import neurram_pkg::*;

  localparam int SD      = 4;
  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 2;

  logic        clk = 1'b0;
  logic        rst, start, so_data, rd_en, sel;
  logic [11:0] num_bits;
  logic        a_busy, a_done, a_so_shift, a_empty, a_valid;
  logic        b_busy, b_done, b_so_shift, b_empty, b_valid;
  logic [31:0] a_dout, b_dout;
  logic        busy, done, so_shift, empty, valid;
  logic [31:0] dout;

  always #5 clk = ~clk;

  core_readout_packer #(.DEPTH(DEPTH_A), .SHIFT_DIV(SD)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .num_bits(num_bits),
    .busy(a_busy), .done(a_done), .so_shift(a_so_shift), .so_data(so_data),
    .rd_en(rd_en), .dout(a_dout), .empty(a_empty), .valid(a_valid));

  core_readout_packer #(.DEPTH(DEPTH_B), .SHIFT_DIV(SD)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .num_bits(num_bits),
    .busy(b_busy), .done(b_done), .so_shift(b_so_shift), .so_data(so_data),
    .rd_en(rd_en), .dout(b_dout), .empty(b_empty), .valid(b_valid));

  assign busy     = sel ? b_busy     : a_busy;
  assign done     = sel ? b_done     : a_done;
  assign so_shift = sel ? b_so_shift : a_so_shift;
  assign empty    = sel ? b_empty    : a_empty;
  assign valid    = sel ? b_valid    : a_valid;
  assign dout     = sel ? b_dout     : a_dout;

  int          checks = 0, failures = 0;
  int          cyc = 0, shift_cnt = 0, done_cnt = 0, valid_cnt = 0;
  int          done_cyc = 0, last_shift_cyc = 0, base = 0, start_cyc = 0;
  bit          gap_en = 1'b0, mon_en = 1'b0;
  logic        stream [0:4095];
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;
  logic [31:0] pat [2];
  logic        prev_rd_ok = 1'b0, prev_rst = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on valid, checks read latency, feeds so_data.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_timing", {31'd0, valid}, {31'd0, prev_rd_ok & prev_rst});
      if (valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dout_unexpected actual=0x%08h expected=none", dout);
        end else begin
          exp_w = exp_q.pop_front();
          chk("dout", dout, exp_w);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (so_shift) begin
        if (gap_en && (shift_cnt - base) > 0)
          chk("shift_gap", cyc - last_shift_cyc,
              (((shift_cnt - base) % 32) == 0) ? SD + 2 : SD + 1);
        last_shift_cyc = cyc;
        so_data = stream[(shift_cnt - base) & 4095];
        shift_cnt++;
      end
    end
    prev_rd_ok = rd_en & ~empty;
    prev_rst   = rst;
  end

  // Fill the bit stream, push the expected words, and issue a start.
  task automatic launch(input int n, input int mode);
    logic [31:0] w;
    base = shift_cnt;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       begin w = pat[i / 32]; stream[i] = w[i % 32]; end
        1:       stream[i] = 1'b1;
        default: stream[i] = 1'($urandom);
      endcase
    end
    for (int k = 0; k < (n + 31) / 32; k++) begin
      w = 32'd0;
      for (int b = 0; b < 32; b++)
        if (k * 32 + b < n) w = w | ({31'd0, stream[k * 32 + b]} << b);
      exp_q.push_back(w);
    end
    start_cyc = cyc;
    start     = 1'b1;
    num_bits  = 12'(n);
    @(posedge clk); #1;
    start     = 1'b0;
    num_bits  = 12'($urandom);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) ok = 1'b1;
    end
    chk({name, "_done_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic read_for(input int n);
    rd_en = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rd_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    int v0, d0;
    pat[0] = 32'hA5A5_0F0F;
    pat[1] = 32'h1234_5678;
    rst = 1'b0; start = 1'b0; so_data = 1'b0; rd_en = 1'b0; sel = 1'b0;
    num_bits = 12'd0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_busy",  {31'd0, a_busy},     32'd0);
    chk("rst_done",  {31'd0, a_done},     32'd0);
    chk("rst_shift", {31'd0, a_so_shift}, 32'd0);
    chk("rst_valid", {31'd0, a_valid},    32'd0);
    chk("rst_dout",  a_dout,              32'd0);
    chk("rst_empty", {31'd0, a_empty},    32'd1);
    chk("rst_empty_b", {31'd0, b_empty},  32'd1);
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // 1: 64-bit fixed pattern, reads held off until done.
    d0 = done_cnt;
    gap_en = 1'b1;
    launch(64, 0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(1000, "t1");
    repeat (3) begin @(posedge clk); #1; end
    gap_en = 1'b0;
    chk("t1_shifts", shift_cnt - base, 32'd64);
    chk("t1_done_once", done_cnt - d0, 32'd1);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    v0 = valid_cnt;
    read_for(6);
    chk("t1_valids", valid_cnt - v0, 32'd2);
    chk("t1_sb_empty", exp_q.size(), 32'd0);

    // 2: 40 ones -> full word then zero-padded partial word.
    launch(40, 1);
    wait_done(1000, "t2");
    v0 = valid_cnt;
    read_for(6);
    chk("t2_valids", valid_cnt - v0, 32'd2);
    chk("t2_sb_empty", exp_q.size(), 32'd0);

    // 3: zero-length request.
    launch(0, 2);
    wait_done(10, "t3");
    chk("t3_done_lat", done_cyc - start_cyc, 32'd2);
    chk("t3_shifts", shift_cnt - base, 32'd0);
    chk("t3_empty", {31'd0, empty}, 32'd1);

    // 4: depth-2 FIFO backpressure, 128 bits.
    sel = 1'b1;
    @(posedge clk); #1;
    d0 = done_cnt;
    launch(128, 2);
    repeat (900) begin @(posedge clk); #1; end
    chk("t4_stall_shifts", shift_cnt - base, (DEPTH_B + 1) * 32);
    chk("t4_no_done", done_cnt - d0, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    v0 = valid_cnt;
    rd_en = 1'b1;
    wait_done(1000, "t4");
    read_for(4);
    chk("t4_shifts", shift_cnt - base, 32'd128);
    chk("t4_valids", valid_cnt - v0, 32'd4);
    chk("t4_sb_empty", exp_q.size(), 32'd0);
    sel = 1'b0;
    @(posedge clk); #1;

    // 5: rd_en held high during a 96-bit readout.
    v0 = valid_cnt;
    rd_en = 1'b1;
    launch(96, 2);
    wait_done(1000, "t5");
    read_for(3);
    chk("t5_valids", valid_cnt - v0, 32'd3);
    chk("t5_sb_empty", exp_q.size(), 32'd0);

    // 6: reset after 50 shifts of a 256-bit readout, then a fresh 32-bit one.
    launch(256, 2);
    for (int i = 0; i < 1000 && (shift_cnt - base) < 50; i++) begin
      @(posedge clk); #1;
    end
    chk("t6_reached50", shift_cnt - base, 32'd50);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_valid", {31'd0, valid}, 32'd0);
    @(posedge clk); #1;
    v0 = valid_cnt;
    launch(32, 2);
    wait_done(1000, "t6");
    read_for(4);
    chk("t6_valids", valid_cnt - v0, 32'd1);
    chk("t6_sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
